// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and sizing helpers for the nibble-serial adder.
package nibble_serial_adder_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int NIB_W = 4;

    function automatic int num_nib(input int width);
        return width / NIB_W;
    endfunction

    function automatic int idx_width(input int nnib);
        return (nnib > 1) ? $clog2(nnib) : 1;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_adder.sv
// 4-bit ripple adder slice exposing per-bit propagate and generate.
module adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout,
    output logic [3:0] p,
    output logic [3:0] g
);

    logic [4:0] c;

    assign p = a ^ b;
    assign g = a & b;

    always_comb begin
        c[0] = cin;
        for (int i = 0; i < 4; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
    end

    assign sum  = p ^ c[3:0];
    assign cout = c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: feeds one 4-bit slice a nibble per clock, LSB first,
// and returns the word result plus carry/overflow/propagate/generate flags.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             grp_p,
    output logic             grp_g
);

    localparam int NUM_NIB = num_nib(WIDTH);
    localparam int IDX_W   = idx_width(NUM_NIB);

    if (((WIDTH % NIB_W) != 0) || (WIDTH < NIB_W)) begin : g_width_chk
        $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
    end

    state_t             state;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               carry_q;
    logic               gen_q;
    logic               prop_q;
    logic [IDX_W-1:0]   idx;

    logic [NIB_W-1:0]   a_nib;
    logic [NIB_W-1:0]   b_nib;
    logic [NIB_W-1:0]   s_sum;
    logic [NIB_W-1:0]   s_p;
    logic [NIB_W-1:0]   s_g;
    logic               s_cout;
    logic               gen_nxt;
    logic               last_nib;

    adder u_slice (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry_q),
        .sum  (s_sum),
        .cout (s_cout),
        .p    (s_p),
        .g    (s_g)
    );

    // Operand nibble select and running word-generate across the current nibble.
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int n = 0; n < NUM_NIB; n++) begin
            if (idx == IDX_W'(n)) begin
                a_nib = a_q[n*NIB_W +: NIB_W];
                b_nib = b_q[n*NIB_W +: NIB_W];
            end
        end
        gen_nxt = gen_q;
        for (int i = 0; i < NIB_W; i++) begin
            gen_nxt = s_g[i] | (s_p[i] & gen_nxt);
        end
    end

    assign last_nib = (idx == IDX_W'(NUM_NIB - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            carry_q   <= 1'b0;
            gen_q     <= 1'b0;
            prop_q    <= 1'b0;
            idx       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            grp_p     <= 1'b0;
            grp_g     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        carry_q  <= cin;
                        gen_q    <= 1'b0;
                        prop_q   <= 1'b1;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    for (int n = 0; n < NUM_NIB; n++) begin
                        if (idx == IDX_W'(n)) sum[n*NIB_W +: NIB_W] <= s_sum;
                    end
                    carry_q <= s_cout;
                    gen_q   <= gen_nxt;
                    prop_q  <= prop_q & (&s_p);
                    idx     <= idx + 1'b1;
                    if (last_nib) begin
                        cout      <= s_cout;
                        grp_p     <= prop_q & (&s_p);
                        grp_g     <= gen_nxt;
                        // Carry into the MSB is p[3]^sum[3] of the top nibble.
                        ovf       <= s_p[NIB_W-1] ^ s_sum[NIB_W-1] ^ s_cout;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Randomized self-checking bench for nibble_serial_adder against a plain a+b+cin model.
module tb_nibble_serial_adder;

    localparam int W       = 16;
    localparam int NUM_NIB = W / 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         grp_p;
    logic         grp_g;

    int n_tests = 0;
    int n_fail  = 0;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .grp_p     (grp_p),
        .grp_g     (grp_g)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model from word-level arithmetic.
    task automatic check_result(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                                input logic tc);
        logic [W:0] full;
        logic [W:0] nocin;
        logic       e_ovf;
        full  = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tc};
        nocin = {1'b0, ta} + {1'b0, tb};
        e_ovf = (ta[W-1] == tb[W-1]) && (full[W-1] != ta[W-1]);
        chk({tag, ".sum"},   sum,   full[W-1:0]);
        chk({tag, ".cout"},  cout,  full[W]);
        chk({tag, ".ovf"},   ovf,   e_ovf);
        chk({tag, ".grp_p"}, grp_p, &(ta ^ tb));
        chk({tag, ".grp_g"}, grp_g, nocin[W]);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("in_ready_wait", in_ready, 1'b1);
    endtask

    // Accept one operation, run it to DONE, check, then release it.
    task automatic do_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic tc, input bit scramble, input int hold);
        int n;
        wait_ready();
        a = ta; b = tb; cin = tc; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            if (scramble) begin
                a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
                in_valid = 1'($urandom); out_ready = 1'($urandom);
            end
            @(posedge clk); #1; n++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk({tag, ".latency"}, n, NUM_NIB);
        chk({tag, ".in_ready_done"}, in_ready, 1'b0);
        check_result(tag, ta, tb, tc);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk({tag, ".hold_valid"}, out_valid, 1'b1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, ".drop_valid"}, out_valid, 1'b0);
    endtask

    initial begin
        logic [W-1:0] held_sum;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        int           n;

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.sum", sum, '0);
        chk("rst.out_valid", out_valid, 1'b0);
        chk("rst.in_ready", in_ready, 1'b1);
        chk("rst.flags", {cout, ovf, grp_p, grp_g}, 4'b0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_op("t1", 16'h1234, 16'h4321, 1'b0, 1'b0, 0);
        chk("t1.abs_sum", sum, 16'h5555);
        do_op("t2", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 0);
        chk("t2.abs", {sum, cout, grp_p, grp_g}, {16'h0000, 3'b110});
        do_op("t3a", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
        chk("t3a.abs", {sum, ovf}, {16'h8000, 1'b1});
        do_op("t3b", 16'h8000, 16'h8000, 1'b0, 1'b0, 0);
        chk("t3b.abs", {sum, cout, ovf, grp_g}, {16'h0000, 3'b111});

        // Backpressure in DONE while new requests are offered.
        wait_ready();
        a = 16'h0102; b = 16'h0304; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("t4.latency", n, NUM_NIB);
        held_sum = sum;
        chk("t4.sum", held_sum, 16'h0407);
        a = 16'h2222; b = 16'h3333; cin = 1'b0;
        for (int h = 0; h < 3; h++) begin
            in_valid = ~in_valid;
            @(posedge clk); #1;
            chk("t4.hold_valid", out_valid, 1'b1);
            chk("t4.hold_sum", sum, held_sum);
            chk("t4.hold_ready", in_ready, 1'b0);
        end
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("t4.release_valid", out_valid, 1'b0);
        chk("t4.release_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("t4.accepted", in_ready, 1'b0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("t4b.latency", n, NUM_NIB);
        check_result("t4b", 16'h2222, 16'h3333, 1'b0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset in the middle of RUN.
        wait_ready();
        a = 16'hABCD; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("t5.rst_sum", sum, '0);
        chk("t5.rst_flags", {out_valid, cout, ovf, grp_p, grp_g}, 5'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int h = 0; h < NUM_NIB + 2; h++) begin
            @(posedge clk); #1;
            chk("t5.no_valid", out_valid, 1'b0);
        end
        do_op("t5b", 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 0);
        chk("t5b.abs", {sum, cout}, {16'h1000, 1'b0});

        // Random operations, operands and handshakes scrambled during RUN.
        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            if (i % 8 == 0) rb = ~ra;
            do_op("rnd", ra, rb, rc, 1'b1, int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
Multi-cycle WIDTH-bit adder that drives one instance of the team's existing 4-bit `adder` slice. It issues one nibble per clock, LSB first, and holds the ripple carry in a register between nibbles. It sits directly upstream of the slice, sequencing operands into it and collecting its sum/cout/p/g. The result is returned on a valid/ready handshake, together with word-level flags for the downstream ALU control.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 4, otherwise elaboration fails
NUM_NIB, WIDTH/4, derived nibble count (not overridable)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand request
in_ready  output  1  block can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry into bit 0
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
sum  output  WIDTH  a+b+cin, modulo 2^WIDTH
cout  output  1  carry out of MSB
ovf  output  1  two's-complement overflow
grp_p  output  1  word propagate: AND over all bits of (a^b)
grp_g  output  1  word generate: carry out of MSB with carry-in forced to 0

Behaviour:
- Reset (async assert, any state): state=IDLE; sum=0, cout=0, ovf=0, grp_p=0, grp_g=0, out_valid=0; carry/nibble-index/operand registers cleared. in_ready=1 once in IDLE.
- Reset mid-RUN or mid-DONE abandons the operation; no partial result is ever presented.
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE: in_ready=1. On a clk edge with in_valid=1:
  - latch a, b;
  - carry register <- cin;
  - gen register <- 0;
  - grp_p register <- 1;
  - nibble index <- 0;
  - go to RUN.
- RUN: in_ready=0. Each edge:
  - feed nibble[idx] of the latched a/b and the carry register to the slice;
  - write the slice sum into sum[4*idx+3:4*idx];
  - carry <- slice cout;
  - grp_p &= &p_nibble;
  - gen register <- the bitwise recurrence G = g_i | (p_i & G), evaluated over the nibble's 4 bits LSB->MSB using slice p/g;
  - idx++.
  - On the edge processing idx=NUM_NIB-1, also load cout, grp_p, grp_g and ovf, then go to DONE.
- ovf = (carry into MSB) XOR cout. Carry into MSB = a[WIDTH-1]^b[WIDTH-1]^sum[WIDTH-1], taken from the final nibble.
- Latency: out_valid rises exactly NUM_NIB edges after the accepting edge (4 for WIDTH=16).
- DONE: out_valid=1, in_ready=0. All result outputs are stable. On an edge with out_ready=1, go to IDLE and drop out_valid. Result outputs hold their values until the next operation overwrites them nibble by nibble.
- in_valid in RUN/DONE is ignored and not queued. Operand changes after acceptance have no effect.
- out_ready while not in DONE is ignored.
- Throughput: one operation per NUM_NIB+2 cycles, assuming out_ready is already high.
- No combinational path from in_valid or out_ready to any output.

Decomposition:
- Shared package:
  - state enum {IDLE, RUN, DONE};
  - NIB_W=4;
  - function returning NUM_NIB from WIDTH;
  - nibble-index width = clog2(NUM_NIB), minimum 1.
- Sub-module: one instance of the existing 4-bit `adder` slice, ports (a,b,cin,sum,cout,p,g). No other sub-modules.
- The FSM, carry/gen registers and result assembly live in nibble_serial_adder.

Test Plan:
1. WIDTH=16, a=0x1234, b=0x4321, cin=0 -> out_valid exactly 4 edges after accept; sum=0x5555, cout=0, ovf=0, grp_p=0, grp_g=0.
2. a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1, ovf=0, grp_p=1, grp_g=0. Confirms the carry ripples through all 4 nibbles.
3. a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1, grp_g=0. Then a=0x8000, b=0x8000, cin=0 -> sum=0x0000, cout=1, ovf=1, grp_g=1.
4. Hold out_ready=0 for 3 cycles in DONE while pulsing in_valid with new operands -> out_valid and sum held, in_ready=0, no new operation starts. out_ready=1 -> IDLE, then the new request is accepted.
5. Accept a=0xABCD, b=0x1111, assert rst on the 2nd RUN edge -> all outputs 0 immediately, no out_valid. After release, a=0x0F0F, b=0x00F1, cin=0 -> sum=0x1000, cout=0.
6. Change a/b/cin during RUN -> result matches the latched operands only. Also run 1000 random back-to-back operations against a behavioural a+b+cin model.
